// File: rtl/sha256d_engine.sv
// Iterative SHA-256 / SHA-256d engine for an 80-byte block header with a target compare.
// Rounds per clock are configurable; the FSM walks the padded blocks and raises a one-cycle done.
module sha256d_engine #(
    parameter int PASSES           = 2,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [639:0] header,
    input  logic [255:0] target,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest,
    output logic         hit
);

    if (PASSES != 1 && PASSES != 2) begin : g_bad_passes
        $error("sha256d_engine: PASSES must be 1 or 2");
    end
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rpc
        $error("sha256d_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef logic [0:7][31:0]  hash_t;
    typedef logic [0:15][31:0] window_t;

    typedef enum logic [2:0] {
        IDLE, B1_ROUND, B1_ADD, B2_ROUND, B2_ADD, P2_ROUND, P2_ADD, FIN
    } fsm_t;

    localparam logic [5:0] RND_STEP = 6'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] LAST_RND = 6'(64 - ROUNDS_PER_CYCLE);

    localparam hash_t H_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [255:0] byte_rev(input logic [255:0] x);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = x[255-8*i -: 8];
        end
        return r;
    endfunction

    fsm_t          state, state_next;
    logic [5:0]    rnd;
    window_t       w, rnd_w;
    hash_t         wv, rnd_wv;
    hash_t         hs, hs_sum;
    hash_t         first_hash;
    logic [127:0]  tail;
    logic [255:0]  tgt;
    logic [255:0]  final_hash;
    logic          last_round;

    assign last_round = (rnd == LAST_RND);
    // A single pass already ends with the block-2 result, which lives in first_hash.
    assign final_hash = (PASSES == 2) ? hs : first_hash;

    // Unrolled compression rounds; the schedule window slides one word per round.
    always_comb begin
        hash_t       v;
        window_t     win;
        logic [31:0] t1, t2;
        logic [5:0]  idx;
        // NOTE: every variable gets a default before any conditional or loop so no latch is inferred.
        v   = wv;
        win = w;
        t1  = '0;
        t2  = '0;
        idx = rnd;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            idx = rnd + 6'(j);
            t1  = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[idx] + win[0];
            t2  = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v   = {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
            win = {win[1:15], ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0]};
        end
        rnd_wv = v;
        rnd_w  = win;
    end

    always_comb begin
        hs_sum = '0;
        for (int i = 0; i < 8; i++) begin
            hs_sum[i] = hs[i] + wv[i];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = B1_ROUND;
            B1_ROUND: if (last_round) state_next = B1_ADD;
            B1_ADD:   state_next = B2_ROUND;
            B2_ROUND: if (last_round) state_next = B2_ADD;
            B2_ADD:   state_next = (PASSES == 2) ? P2_ROUND : FIN;
            P2_ROUND: if (last_round) state_next = P2_ADD;
            P2_ADD:   state_next = FIN;
            FIN:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rnd        <= '0;
            w          <= '0;
            wv         <= '0;
            hs         <= '0;
            first_hash <= '0;
            tail       <= '0;
            tgt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            digest     <= '0;
            hit        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w    <= header[639:128];
                        wv   <= H_INIT;
                        hs   <= H_INIT;
                        tail <= header[127:0];
                        tgt  <= target;
                        rnd  <= '0;
                        busy <= 1'b1;
                    end
                end
                B1_ROUND, B2_ROUND, P2_ROUND: begin
                    wv  <= rnd_wv;
                    w   <= rnd_w;
                    rnd <= rnd + RND_STEP;
                end
                B1_ADD: begin
                    hs  <= hs_sum;
                    wv  <= hs_sum;
                    w   <= {tail, 8'h80, 312'd0, 64'd640};
                    rnd <= '0;
                end
                B2_ADD: begin
                    // Pass 2 restarts from the standard IV over the padded pass-1 digest.
                    first_hash <= hs_sum;
                    hs         <= H_INIT;
                    wv         <= H_INIT;
                    w          <= {hs_sum, 8'h80, 184'd0, 64'd256};
                    rnd        <= '0;
                end
                P2_ADD: begin
                    hs <= hs_sum;
                end
                FIN: begin
                    digest <= final_hash;
                    hit    <= (byte_rev(final_hash) <= tgt);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256d_engine.sv
// Directed bench for sha256d_engine: three configurations driven from one clock and reset.
module tb_sha256d_engine;

    localparam logic [639:0] HDR = 640'h0100000081cd02ab7e569e8bcd9317e2fe99f2de44d49ab2b8851ba4a308000000000000e320b6c2fffc8d750423db8b1eb942ae710e951ed797f7affc8892b0f1fc122bc7f5d74df2b9441a42a14695;
    localparam logic [255:0] PASS1  = 256'hb9d751533593ac10cdfb7b8e03cad8babc67d8eaeac0a3699b82857dacac9390;
    localparam logic [255:0] DBL    = 256'h1dbd981fe6985776b644b173a4d0385ddc1aa2a829688d1e0000000000000000;
    localparam logic [255:0] TGT_EQ = 256'h00000000000000001e8d6829a8a21adc5d38d0a473b144b6765798e61f98bd1d;
    localparam int L_P2R1 = 196;
    localparam int L_P1R2 = 67;
    localparam int L_P2R4 = 52;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   start;
    logic [639:0] header;
    logic [255:0] target;
    logic [2:0]   busy, done, hit;
    logic [255:0] digest [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sha256d_engine #(.PASSES(2), .ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .start(start[0]), .header(header), .target(target),
        .busy(busy[0]), .done(done[0]), .digest(digest[0]), .hit(hit[0])
    );

    sha256d_engine #(.PASSES(1), .ROUNDS_PER_CYCLE(2)) dut_p1 (
        .clk(clk), .reset(reset), .start(start[1]), .header(header), .target(target),
        .busy(busy[1]), .done(done[1]), .digest(digest[1]), .hit(hit[1])
    );

    sha256d_engine #(.PASSES(2), .ROUNDS_PER_CYCLE(4)) dut_r4 (
        .clk(clk), .reset(reset), .start(start[2]), .header(header), .target(target),
        .busy(busy[2]), .done(done[2]), .digest(digest[2]), .hit(hit[2])
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1ns after an edge: start is accepted on the next edge and we return 1ns after it.
    task automatic launch(input int u);
        start[u] = 1'b1;
        tick(1);
        start[u] = 1'b0;
    endtask

    task automatic wait_done(input int u, output int cycles);
        cycles = 0;
        do begin
            tick(1);
            cycles++;
        end while (!done[u] && cycles < 400);
        n_checks++;
        if (done[u] !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout[%0d]: no done within %0d cycles", u, cycles);
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        start  = '0;
        header = HDR;
        target = '0;
        tick(2);
        n_checks++;
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy[0]); end
        n_checks++;
        if (done[0] !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done[0]); end
        n_checks++;
        if (digest[0] !== 256'd0) begin n_fail++; $display("FAIL reset_digest: got %h expected 0", digest[0]); end
        n_checks++;
        if (hit[0] !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b expected 0", hit[0]); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_double_hash;
        int c;
        header = HDR;
        target = '0;
        launch(0);
        n_checks++;
        if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL dbl_busy_after_accept: got %b expected 1", busy[0]); end
        wait_done(0, c);
        n_checks++;
        if (c != L_P2R1) begin n_fail++; $display("FAIL dbl_latency: got %0d expected %0d", c, L_P2R1); end
        n_checks++;
        if (digest[0] !== DBL) begin n_fail++; $display("FAIL dbl_digest: got %h expected %h", digest[0], DBL); end
        n_checks++;
        if (dut.first_hash !== PASS1) begin n_fail++; $display("FAIL dbl_first_hash: got %h expected %h", dut.first_hash, PASS1); end
        n_checks++;
        if (hit[0] !== 1'b0) begin n_fail++; $display("FAIL dbl_hit_zero_target: got %b expected 0", hit[0]); end
        n_checks++;
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL dbl_busy_at_done: got %b expected 0", busy[0]); end
        tick(1);
        n_checks++;
        if (done[0] !== 1'b0) begin n_fail++; $display("FAIL dbl_done_pulse_width: got %b expected 0", done[0]); end
        n_checks++;
        if (digest[0] !== DBL) begin n_fail++; $display("FAIL dbl_digest_held: got %h expected %h", digest[0], DBL); end
    endtask

    task automatic test_single_pass;
        int c;
        header = HDR;
        launch(1);
        wait_done(1, c);
        n_checks++;
        if (c != L_P1R2) begin n_fail++; $display("FAIL p1_latency: got %0d expected %0d", c, L_P1R2); end
        n_checks++;
        if (digest[1] !== PASS1) begin n_fail++; $display("FAIL p1_digest: got %h expected %h", digest[1], PASS1); end
        tick(1);
    endtask

    task automatic test_unroll4;
        int c;
        header = HDR;
        launch(2);
        wait_done(2, c);
        n_checks++;
        if (c != L_P2R4) begin n_fail++; $display("FAIL r4_latency: got %0d expected %0d", c, L_P2R4); end
        n_checks++;
        if (digest[2] !== DBL) begin n_fail++; $display("FAIL r4_digest: got %h expected %h", digest[2], DBL); end
        n_checks++;
        if (dut_r4.first_hash !== PASS1) begin n_fail++; $display("FAIL r4_first_hash: got %h expected %h", dut_r4.first_hash, PASS1); end
        tick(1);
    endtask

    task automatic test_target;
        logic [255:0] tgts [3];
        logic         exp_hit [3];
        int           c;
        tgts[0] = TGT_EQ;        exp_hit[0] = 1'b1;
        tgts[1] = TGT_EQ - 1;    exp_hit[1] = 1'b0;
        tgts[2] = '1;            exp_hit[2] = 1'b1;
        header = HDR;
        for (int i = 0; i < 3; i++) begin
            target = tgts[i];
            launch(2);
            wait_done(2, c);
            n_checks++;
            if (hit[2] !== exp_hit[i]) begin
                n_fail++;
                $display("FAIL target_hit[%0d]: got %b expected %b", i, hit[2], exp_hit[i]);
            end
            tick(1);
        end
    endtask

    task automatic test_ignore_start;
        int c;
        header = HDR;
        target = TGT_EQ;
        launch(0);
        tick(20);
        header   = ~HDR;
        target   = '0;
        start[0] = 1'b1;
        tick(2);
        start[0] = 1'b0;
        n_checks++;
        if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: got %b expected 1", busy[0]); end
        wait_done(0, c);
        n_checks++;
        if (c + 22 != L_P2R1) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", c + 22, L_P2R1); end
        n_checks++;
        if (digest[0] !== DBL) begin n_fail++; $display("FAIL ignore_digest: got %h expected %h", digest[0], DBL); end
        n_checks++;
        if (hit[0] !== 1'b1) begin n_fail++; $display("FAIL ignore_hit: got %b expected 1", hit[0]); end
        header = HDR;
        tick(1);
    endtask

    task automatic test_back_to_back;
        int c;
        header   = HDR;
        target   = TGT_EQ;
        start[2] = 1'b1;
        tick(1);
        wait_done(2, c);
        n_checks++;
        if (c != L_P2R4) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", c, L_P2R4); end
        n_checks++;
        if (busy[2] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_at_done: got %b expected 0", busy[2]); end
        tick(1);
        n_checks++;
        if (busy[2] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: got busy %b expected 1", busy[2]); end
        start[2] = 1'b0;
        wait_done(2, c);
        n_checks++;
        if (c != L_P2R4) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected %0d", c, L_P2R4); end
        n_checks++;
        if (digest[2] !== DBL) begin n_fail++; $display("FAIL b2b_digest: got %h expected %h", digest[2], DBL); end
        n_checks++;
        if (hit[2] !== 1'b1) begin n_fail++; $display("FAIL b2b_hit: got %b expected 1", hit[2]); end
        tick(1);
    endtask

    task automatic test_reset_mid;
        int   c;
        logic seen;
        header = HDR;
        target = TGT_EQ;
        launch(0);
        tick(39);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", busy[0]); end
        n_checks++;
        if (done[0] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done: got %b expected 0", done[0]); end
        n_checks++;
        if (digest[0] !== 256'd0) begin n_fail++; $display("FAIL mid_reset_digest: got %h expected 0", digest[0]); end
        n_checks++;
        if (hit[0] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_hit: got %b expected 0", hit[0]); end
        tick(2);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (200) begin
            tick(1);
            if (done[0] === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_done: got done pulse, expected none"); end
        launch(0);
        wait_done(0, c);
        n_checks++;
        if (c != L_P2R1) begin n_fail++; $display("FAIL restart_latency: got %0d expected %0d", c, L_P2R1); end
        n_checks++;
        if (digest[0] !== DBL) begin n_fail++; $display("FAIL restart_digest: got %h expected %h", digest[0], DBL); end
        n_checks++;
        if (hit[0] !== 1'b1) begin n_fail++; $display("FAIL restart_hit: got %b expected 1", hit[0]); end
        tick(1);
    endtask

    initial begin
        test_reset;
        test_double_hash;
        test_single_pass;
        test_unroll4;
        test_target;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
